rrc_interpolator: RTL and testbench

Transmit-side root-raised-cosine pulse shaper: a 4x polyphase interpolating FIR that accepts one signed symbol every four clocks over a ready/valid handshake and emits one shaped sample per clock. It runs on the 2 MHz sample clock, takes 500 ksym/s symbols, and feeds the DAC path. Its coefficient set is identical to the receive matched filter, so TX and RX form the matched RRC pair.

---
 rtl/rrc_interpolator.sv | 101 ++++++++++
 tb/tb_rrc_interpolator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rrc_interpolator.sv
// 4x polyphase root-raised-cosine interpolator: one symbol in every four clocks,
// one shaped, saturated 12-bit sample out every clock.
module rrc_interpolator (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [11:0] out_data,
    output logic               out_valid,
    output logic               underflow
);

    localparam int NumTaps   = 21;
    localparam int Interp    = 4;
    localparam int PadTaps   = 24;
    localparam int TapsPerPh = PadTaps / Interp;

    localparam logic signed [13:0] H [NumTaps] = '{
        -14'sd86,   14'sd89,   14'sd245,  14'sd89,   -14'sd433, -14'sd906,
        -14'sd613,  14'sd906,  -14'sd16,  14'sd5632, 14'sd6570, 14'sd5632,
        -14'sd16,   14'sd906,  -14'sd613, -14'sd906, -14'sd433, 14'sd89,
        14'sd245,   14'sd89,   -14'sd86
    };

    // Taps beyond the prototype length are the zero padding.
    function automatic logic signed [13:0] coef(input logic [4:0] idx);
        if (int'(idx) < NumTaps) begin
            coef = H[idx];
        end else begin
            coef = '0;
        end
    endfunction

    logic        [1:0]  ph_q, ph_d;
    logic signed [11:0] s_q [TapsPerPh];
    logic signed [11:0] s_d [TapsPerPh];
    logic signed [11:0] out_data_q, out_data_d;
    logic               out_valid_q;
    logic               underflow_q, underflow_d;

    logic signed [25:0] prod;
    logic signed [28:0] acc;
    logic signed [16:0] shifted;
    logic        [4:0]  tap_idx;

    always_comb begin
        ph_d        = ph_q + 2'd1;
        s_d         = s_q;
        underflow_d = 1'b0;
        if (ph_q == 2'd3) begin
            for (int k = TapsPerPh - 1; k > 0; k--) begin
                s_d[k] = s_q[k-1];
            end
            s_d[0]      = in_valid ? in_data : 12'sd0;
            underflow_d = ~in_valid;
        end
    end

    // Sum of h[4k+ph]*s[k]; 29 bits cannot overflow for 12x14-bit products.
    always_comb begin
        acc     = '0;
        prod    = '0;
        tap_idx = '0;
        for (int k = 0; k < TapsPerPh; k++) begin
            tap_idx = 5'(k * Interp) + 5'(ph_q);
            prod    = 26'(coef(tap_idx)) * 26'(s_q[k]);
            acc     = acc + 29'(prod);
        end
        shifted = 17'(acc >>> 12);
        if (shifted > 17'sd2047) begin
            out_data_d = 12'sd2047;
        end else if (shifted < -17'sd2048) begin
            out_data_d = -12'sd2048;
        end else begin
            out_data_d = shifted[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= '0;
            s_q         <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            s_q         <= s_d;
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            underflow_q <= underflow_d;
        end
    end

    assign in_ready  = (ph_q == 2'd3);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_rrc_interpolator.sv
// Bench for rrc_interpolator: direct-form convolution of the zero-stuffed
// symbol stream feeds a scoreboard queue, plus fixed-value spot checks.
module tb_rrc_interpolator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [11:0] out_data;
    logic               out_valid;
    logic               underflow;

    rrc_interpolator dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int u[24];
    int cyc = 0;

    int h[24] = '{-86, 89, 245, 89, -433, -906, -613, 906, -16, 5632, 6570, 5632,
                  -16, 906, -613, -906, -433, 89, 245, 89, -86, 0, 0, 0};
    int imp[22] = '{-22, 22, 61, 22, -109, -227, -154, 226, -4, 1408, 1642, 1408,
                    -4, 226, -154, -227, -109, 22, 61, 22, -22, 0};
    int dc[4] = '{-134, 726, 729, 726};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // u[n] is the zero-stuffed input taken n+1 edges before the edge being predicted.
    function automatic int model_out();
        longint acc = 0;
        for (int n = 0; n < 24; n++) acc += longint'(h[n]) * longint'(u[n]);
        acc = acc >>> 12;
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        return int'(acc);
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_underflow", int'(underflow), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end
        for (int i = 0; i < 24; i++) u[i] = 0;
        cyc = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic v, input int d, output int obs, output int phs);
        logic exp_rdy, exp_uf;
        int   unew;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        in_data  = 12'(d);
        exp_rdy  = (cyc % 4 == 3);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        exp_q.push_back(model_out());
        unew   = (exp_rdy && v) ? d : 0;
        exp_uf = exp_rdy && !v;
        for (int n = 23; n > 0; n--) u[n] = u[n-1];
        u[0] = unew;
        phs  = cyc % 4;
        @(posedge clk);
        #1;
        cyc++;
        obs = int'(out_data);
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("out_data", obs, exp_q.pop_front());
        chk("out_valid", int'(out_valid), 1);
        chk("underflow", int'(underflow), int'(exp_uf));
    endtask

    task automatic run(input int n, input logic v, input int d);
        int obs, phs;
        for (int i = 0; i < n; i++) step(v, d, obs, phs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int obs, phs, uf_cnt;

        do_reset(3);

        // Impulse: 1024 at the first ready slot, then valid zeros.
        run(3, 1'b0, 0);
        step(1'b1, 1024, obs, phs);
        chk("impulse_accept_phase", phs, 3);
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 0, obs, phs);
            chk("impulse", obs, imp[i]);
        end
        run(8, 1'b1, 0);

        // DC steady state.
        run(48, 1'b1, 512);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 512, obs, phs);
            chk("dc_phase", obs, dc[phs]);
        end

        // Saturation both ways.
        run(40, 1'b1, 2047);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2047, obs, phs);
            if (phs == 2) chk("sat_pos_ph2", obs, 2047);
            if (phs == 0) chk("sat_pos_ph0", obs, -535);
        end
        run(40, 1'b1, -2048);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, -2048, obs, phs);
            if (phs == 2) chk("sat_neg_ph2", obs, -2048);
        end

        // Underflow: one missed ready slot in a random stream.
        for (int i = 0; i < 16; i++) step(1'b1, int'($urandom_range(4095)) - 2048, obs, phs);
        uf_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 9 || i == 10 || i == 11) step(1'b0, 0, obs, phs);
            else step(1'b1, int'($urandom_range(4095)) - 2048, obs, phs);
            if (underflow) uf_cnt++;
        end
        chk("underflow_pulses", uf_cnt, 1);

        // Handshake: valid always high, data changing every clock.
        for (int i = 0; i < 64; i++) step(1'b1, int'($urandom_range(4095)) - 2048, obs, phs);

        // Reset mid-stream during an impulse response.
        run(28, 1'b1, 0);
        while (cyc % 4 != 3) step(1'b1, 0, obs, phs);
        step(1'b1, 1024, obs, phs);
        run(10, 1'b1, 0);
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, obs, phs);
            chk("post_rst_zero", obs, 0);
        end
        while (cyc % 4 != 3) step(1'b1, 0, obs, phs);
        step(1'b1, -1024, obs, phs);
        for (int i = 0; i < 24; i++) step(1'b1, 0, obs, phs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
